demux1to8_deser: RTL and testbench

- Serial-to-parallel counterpart of the team's 8:1 mux path.
- Takes one bit per valid/ready handshake and steers it into word slot `d[sel]`, using an internal 3-bit select counter that increments per accepted bit.
- Presents the assembled 8-bit word on a valid/ready output with one word of buffering.
- Sits downstream of any mux-based serializer, which drives bit `d[s]` for s=0..7 (LSB first).

---
 rtl/deser_pkg.sv | 12 +
 rtl/sel_counter.sv | 37 +++
 rtl/demux1to8_deser.sv | 103 ++++++++++
 tb/tb_demux1to8_deser.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared definitions for the serial/parallel mux-demux datapath.
// Optional parity support is enabled by DEMUX1TO8_DESER_PARITY_EN in the users of this package.
package deser_pkg;

    localparam int DESER_W = 8;

    // Returns 1 when the word has an odd number of ones.
    function automatic logic even_parity(input logic [DESER_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sel_counter.sv
// Wrapping select counter 0..MAX with enable, synchronous clear and terminal-count flag.
// Shared by the serializer and deserializer select paths.
module sel_counter #(
    parameter int MAX = 7,
    parameter int CW  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc  = (cnt_q == CW'(MAX));
    assign cnt = cnt_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tc ? '0 : cnt_q + CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/demux1to8_deser.sv
// Serial-to-parallel deserializer: steers each accepted bit into slot sel, buffers one word.
// Define DEMUX1TO8_DESER_PARITY_EN to append an even-parity bit per frame and expose p_perr.
module demux1to8_deser
    import deser_pkg::*;
#(
    parameter  int W     = DESER_W,
`ifdef DEMUX1TO8_DESER_PARITY_EN
    localparam int LAST  = W,
`else
    localparam int LAST  = W - 1,
`endif
    localparam int SEL_W = $clog2(LAST + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_bit,
    output logic             s_ready,
    input  logic             s_clr,
    output logic             p_valid,
    output logic [W-1:0]     p_data,
    input  logic             p_ready,
`ifdef DEMUX1TO8_DESER_PARITY_EN
    output logic             p_perr,
`endif
    output logic [SEL_W-1:0] sel
);

    logic [W-1:0] asm_q, asm_d;
    logic [W-1:0] p_data_q, p_data_d;
    logic         p_valid_q, p_valid_d;
    logic         last;
    logic         accept;
    logic         complete;

    sel_counter #(.MAX(LAST), .CW(SEL_W)) u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .clr   (s_clr),
        .cnt   (sel),
        .tc    (last)
    );

    // Only the frame-closing bit waits for the output buffer; earlier bits always land.
    assign s_ready  = !(last && p_valid_q && !p_ready);
    assign accept   = s_valid && s_ready;
    assign complete = accept && last && !s_clr;

`ifdef DEMUX1TO8_DESER_PARITY_EN
    logic p_perr_q, p_perr_d;
    assign p_perr = p_perr_q;
`endif

    always_comb begin
        asm_d     = asm_q;
        p_data_d  = p_data_q;
        p_valid_d = p_valid_q;
`ifdef DEMUX1TO8_DESER_PARITY_EN
        p_perr_d  = p_perr_q;
`endif
        if (p_valid_q && p_ready)
            p_valid_d = 1'b0;

        if (accept && !s_clr) begin
            for (int i = 0; i < W; i++)
                if (sel == SEL_W'(i))
                    asm_d[i] = s_bit;
        end

        if (complete) begin
`ifdef DEMUX1TO8_DESER_PARITY_EN
            p_data_d = asm_q;
            p_perr_d = even_parity(asm_q) ^ s_bit;
`else
            p_data_d = {s_bit, asm_q[W-2:0]};
`endif
            p_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q     <= '0;
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
`ifdef DEMUX1TO8_DESER_PARITY_EN
            p_perr_q  <= 1'b0;
`endif
        end else begin
            asm_q     <= asm_d;
            p_data_q  <= p_data_d;
            p_valid_q <= p_valid_d;
`ifdef DEMUX1TO8_DESER_PARITY_EN
            p_perr_q  <= p_perr_d;
`endif
        end
    end

    assign p_valid = p_valid_q;
    assign p_data  = p_data_q;

endmodule

// File: tb/tb_demux1to8_deser.sv
// Directed self-checking bench for demux1to8_deser (covers parity mode when
// DEMUX1TO8_DESER_PARITY_EN is defined).
module tb_demux1to8_deser;

`ifdef DEMUX1TO8_DESER_PARITY_EN
    localparam int NB    = 9;
    localparam int SEL_W = 4;
`else
    localparam int NB    = 8;
    localparam int SEL_W = 3;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_bit;
    logic             s_ready;
    logic             s_clr;
    logic             p_valid;
    logic [7:0]       p_data;
    logic             p_ready;
    logic [SEL_W-1:0] sel;
`ifdef DEMUX1TO8_DESER_PARITY_EN
    logic             p_perr;
`endif

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    demux1to8_deser dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_bit   (s_bit),
        .s_ready (s_ready),
        .s_clr   (s_clr),
        .p_valid (p_valid),
        .p_data  (p_data),
        .p_ready (p_ready),
`ifdef DEMUX1TO8_DESER_PARITY_EN
        .p_perr  (p_perr),
`endif
        .sel     (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one bit and returns at the negedge after it is accepted.
    task automatic send_bit(input logic b);
        int n;
        s_valid = 1'b1;
        s_bit   = b;
        n = 0;
        while (!s_ready && n < 50) begin
            stalls++;
            @(negedge clk);
            n++;
        end
        if (n >= 50)
            chk("ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic par);
        logic [8:0] f;
        f = {par, w};
        for (int i = 0; i < NB; i++)
            send_bit(f[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] f;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_bit   = 1'b0;
        s_clr   = 1'b0;
        p_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_p_valid", 32'(p_valid), 32'd0);
        chk("rst_p_data", 32'(p_data), 32'h00);
        chk("rst_s_ready", 32'(s_ready), 32'd1);

        // Single frame 1,0,0,1,1,0,1,0 LSB first -> 0x59
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        chk("mid_sel3", 32'(sel), 32'd3);
        chk("mid_no_valid", 32'(p_valid), 32'd0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
`ifdef DEMUX1TO8_DESER_PARITY_EN
        send_bit(1'b0);
`endif
        chk("w1_valid", 32'(p_valid), 32'd1);
        chk("w1_data", 32'(p_data), 32'h59);
        chk("w1_sel_wrap", 32'(sel), 32'd0);

        // Back-to-back frames with the consumer always ready
        stalls = 0;
        send_frame(8'h59, 1'b0);
        chk("b2b_data0", 32'(p_data), 32'h59);
        chk("b2b_valid0", 32'(p_valid), 32'd1);
        send_frame(8'h93, 1'b0);
        chk("b2b_data1", 32'(p_data), 32'h93);
        chk("b2b_valid1", 32'(p_valid), 32'd1);
        chk("b2b_no_stall", 32'(stalls), 32'd0);
        @(negedge clk);
        chk("drain_valid", 32'(p_valid), 32'd0);

        // Held output: only the closing bit of the next frame stalls
        p_ready = 1'b0;
        send_frame(8'h59, 1'b0);
        chk("hold_data", 32'(p_data), 32'h59);
        stalls = 0;
        f = {1'b0, 8'h93};
        for (int i = 0; i < NB - 1; i++)
            send_bit(f[i]);
        chk("hold_no_early_stall", 32'(stalls), 32'd0);
        chk("hold_sel_last", 32'(sel), 32'(NB - 1));
        s_valid = 1'b1;
        s_bit   = f[NB-1];
        #1;
        chk("hold_s_ready_low", 32'(s_ready), 32'd0);
        @(negedge clk);
        chk("hold_sel_stuck", 32'(sel), 32'(NB - 1));
        chk("hold_data_stable", 32'(p_data), 32'h59);
        chk("hold_valid", 32'(p_valid), 32'd1);
        p_ready = 1'b1;
        #1;
        chk("hold_s_ready_high", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        chk("swap_data", 32'(p_data), 32'h93);
        chk("swap_valid", 32'(p_valid), 32'd1);
        chk("swap_sel", 32'(sel), 32'd0);
        @(negedge clk);
        chk("swap_drained", 32'(p_valid), 32'd0);

        // Resync mid-frame drops the coincident bit
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        chk("clr_pre_sel", 32'(sel), 32'd3);
        s_valid = 1'b1;
        s_bit   = 1'b0;
        s_clr   = 1'b1;
        @(negedge clk);
        s_clr   = 1'b0;
        s_valid = 1'b0;
        chk("clr_sel", 32'(sel), 32'd0);
        chk("clr_p_valid", 32'(p_valid), 32'd0);
        chk("clr_p_data", 32'(p_data), 32'h93);
        p_ready = 1'b0;
        send_frame(8'hA5, 1'b0);
        chk("clr_word", 32'(p_data), 32'hA5);
        chk("clr_word_valid", 32'(p_valid), 32'd1);

        // Asynchronous reset mid-frame with a pending word
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("arst_pre_sel", 32'(sel), 32'd4);
        chk("arst_pre_valid", 32'(p_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_p_valid", 32'(p_valid), 32'd0);
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_p_data", 32'(p_data), 32'h00);
        chk("arst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        p_ready = 1'b1;
        @(negedge clk);

`ifdef DEMUX1TO8_DESER_PARITY_EN
        send_frame(8'h59, 1'b0);
        chk("par_ok_data", 32'(p_data), 32'h59);
        chk("par_ok_perr", 32'(p_perr), 32'd0);
        send_frame(8'h59, 1'b1);
        chk("par_bad_data", 32'(p_data), 32'h59);
        chk("par_bad_perr", 32'(p_perr), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
